uart_rx_os16: RTL and testbench

- Robust UART receiver; the companion serial-in end for the team's UART transmitter.
- Operates in the single clk domain, with no derived clock. A baud-tick enable drives an oversampling bit engine.
- Validates the start bit, samples each bit at its centre, and checks stop bit and optional parity.
- Presents each byte on a valid/ready interface, with framing, parity and overrun status, for a FIFO or register-bank consumer.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_os16_if.sv | 28 ++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_rx_os16.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_os16.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   uart_rx_state_e : receiver frame-walk states
//   UART_DATA_BITS  : payload width of one character
//   uart_div()      : clock cycles per oversample tick, truncated, never below 1
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_e;

  function automatic int uart_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Byte-delivery interface between the UART receiver and its consumer.
//   rx_data    : received byte, stable while rx_valid=1
//   rx_valid   : a byte is presented
//   rx_ready   : consumer takes the byte (handshake = rx_valid & rx_ready)
//   frame_err  : stop bit of the presented byte was 0 (qualified by rx_valid)
//   parity_err : parity mismatch on the presented byte (qualified by rx_valid)
//   overrun    : sticky, a byte was dropped while one was pending
// master = receiver side, slave = consumer side.
interface uart_rx_os16_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;
  logic                      frame_err;
  logic                      parity_err;
  logic                      overrun;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running tick generator: one-clk pulse on tick every DIV clocks.
//   clk, rst : clock and synchronous active-high reset
//   clr      : restart the divider (counter back to 0, no tick)
//   tick     : registered single-cycle enable pulse
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/uart_rx_os16.sv
// Oversampling UART receiver (8 data bits, optional parity, 1 stop bit).
//   clk, rst : clock and synchronous active-high reset
//   rx       : asynchronous serial input, idle high
//   busy     : a frame is being received (state not IDLE)
//   rx_if    : byte + status delivery towards the consumer (master side)
module uart_rx_os16 import uart_pkg::*; #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  output logic           busy,
  uart_rx_os16_if.master rx_if
);
  localparam int                 DIV      = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int                 CNT_W    = $clog2(OVERSAMPLE + 1);
  localparam logic [CNT_W-1:0]   HALF     = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0]   FULL     = CNT_W'(OVERSAMPLE);
  localparam logic [2:0]         LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic tick;

  // Divider free-runs: bit timing is anchored on the oversample count, not on it.
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .tick (tick)
  );

  logic                      rx_meta_q, rx_s_q;
  uart_rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      par_bad_q, par_bad_d;
  logic                      frame_bad_q, frame_bad_d;
  logic                      armed_q, armed_d;
  logic                      deliver_q, deliver_d;

  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      perr_q, perr_d;
  logic                      ovr_q, ovr_d;
  logic                      hs;

  // Frame walk.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_bad_d   = par_bad_q;
    frame_bad_d = frame_bad_q;
    armed_d     = armed_q;
    deliver_d   = 1'b0;
    cnt_inc     = cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        // Only a high-to-low transition starts a frame; a held-low line cannot.
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end
      START: if (tick) begin
        cnt_d = cnt_inc;
        if (cnt_inc == HALF) begin
          if (rx_s_q) begin
            state_d = IDLE;           // glitch, not a start bit
          end else begin
            state_d   = DATA;
            cnt_d     = '0;
            bit_d     = '0;
            par_bad_d = 1'b0;
          end
        end
      end
      DATA: if (tick) begin
        cnt_d = cnt_inc;
        if (cnt_inc == FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: if (tick) begin
        cnt_d = cnt_inc;
        if (cnt_inc == FULL) begin
          cnt_d     = '0;
          par_bad_d = ((^shift_q) ^ rx_s_q) != 1'(PARITY_ODD);
          state_d   = STOP;
        end
      end
      STOP: if (tick) begin
        cnt_d = cnt_inc;
        if (cnt_inc == FULL) begin
          // Leave at mid-stop so the next start edge can follow immediately.
          cnt_d       = '0;
          frame_bad_d = ~rx_s_q;
          deliver_d   = 1'b1;
          armed_d     = rx_s_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-deep output register with overrun tracking.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;
    hs      = valid_q & rx_if.rx_ready;
    if (deliver_q && (!valid_q || hs)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ferr_d  = frame_bad_q;
      perr_d  = par_bad_q;
      if (hs) ovr_d = 1'b0;
    end else if (deliver_q) begin
      ovr_d = 1'b1;                   // pending byte kept, new one dropped
    end else if (hs) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      frame_bad_q <= 1'b0;
      armed_q     <= 1'b0;
      deliver_q   <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      perr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_bad_q   <= par_bad_d;
      frame_bad_q <= frame_bad_d;
      armed_q     <= armed_d;
      deliver_q   <= deliver_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      perr_q      <= perr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: two receivers (no parity / even parity) at
// 1.6 MHz, 10 kbaud, 16x oversampling (160 clk per bit).
module tb_uart_rx_os16;
  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int OS       = 16;
  localparam int BIT_CLKS = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic busy0, busy1;

  uart_rx_os16_if if0();
  uart_rx_os16_if if1();

  uart_rx_os16 #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                 .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .busy(busy0), .rx_if(if0));

  uart_rx_os16 #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                 .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .busy(busy1), .rx_if(if1));

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   start0 = 0;
  int   rise0  = 0;
  logic v0_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if0.rx_valid && !v0_prev) rise0 <= cyc;
    v0_prev <= if0.rx_valid;
  end

  // Reference for channel 0: a one-entry mailbox with a sticky drop flag.
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ferr  = 1'b0;
  logic       m_perr  = 1'b0;
  logic       m_ovr   = 1'b0;

  task automatic model_reset();
    m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (!m_valid) begin
      m_valid = 1'b1; m_data = d; m_ferr = !stop; m_perr = 1'b0;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic model_hs();
    if (m_valid) begin
      m_valid = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input int ch, input logic v);
    if (ch == 0) rx0 = v; else rx1 = v;
  endtask

  task automatic send_frame(input int ch, input logic [7:0] d, input logic stop,
                            input logic pen, input logic pbit);
    if (ch == 0) start0 = cyc;
    set_line(ch, 1'b0); hold(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      set_line(ch, d[i]); hold(BIT_CLKS);
    end
    if (pen) begin
      set_line(ch, pbit); hold(BIT_CLKS);
    end
    set_line(ch, stop); hold(BIT_CLKS);
  endtask

  function automatic logic vld(input int ch);
    return (ch == 0) ? if0.rx_valid : if1.rx_valid;
  endfunction

  task automatic wait_valid(input int ch, input int budget, input string nm);
    int n = 0;
    while (!vld(ch) && n < budget) begin
      @(negedge clk); n++;
    end
    chk({nm, "_arrived"}, vld(ch), 1);
  endtask

  task automatic do_hs(input int ch);
    @(negedge clk);
    if (ch == 0) if0.rx_ready = 1'b1; else if1.rx_ready = 1'b1;
    @(negedge clk);
    if0.rx_ready = 1'b0; if1.rx_ready = 1'b0;
    if (ch == 0) model_hs();
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_valid"},   if0.rx_valid,   m_valid);
    chk({nm, "_data"},    if0.rx_data,    m_data);
    chk({nm, "_ferr"},    if0.frame_err,  m_ferr);
    chk({nm, "_perr"},    if0.parity_err, m_perr);
    chk({nm, "_overrun"}, if0.overrun,    m_ovr);
  endtask

  typedef struct {
    int         ch;
    logic [7:0] d;
    logic       stop;
    logic       pbit;
    logic [7:0] ed;
    logic       ef;
    logic       ep;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] rd;
    logic       rs;

    tbl[0] = '{0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{0, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[2] = '{0, 8'h5B, 1'b0, 1'b0, 8'h5B, 1'b1, 1'b0};
    tbl[3] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[4] = '{1, 8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1};
    tbl[5] = '{1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    tbl[6] = '{1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1};
    tbl[7] = '{1, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0};

    if0.rx_ready = 1'b0;
    if1.rx_ready = 1'b0;
    rst = 1'b1;
    hold(5);
    chk("reset_valid0", if0.rx_valid, 0);
    chk("reset_data0", if0.rx_data, 0);
    chk("reset_ovr0", if0.overrun, 0);
    chk("reset_busy0", busy0, 0);
    chk("reset_valid1", if1.rx_valid, 0);
    chk("reset_perr1", if1.parity_err, 0);
    rst = 1'b0;
    hold(20);
    $display("txn reset: done");

    // Single byte and its latency from the start edge.
    send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0);
    model_frame(8'hA5, 1'b1);
    wait_valid(0, 200, "a5");
    lat = rise0 - start0;
    chk("a5_latency_window", (lat >= 1505 && lat <= 1540), 1);
    chk_model("a5");
    chk("a5_data_const", if0.rx_data, 8'hA5);
    do_hs(0);
    chk("a5_cleared", if0.rx_valid, 0);
    $display("txn byte 0xA5: latency=%0d data=%h", lat, 8'hA5);

    // Short low glitch.
    set_line(0, 1'b0); hold(20);
    chk("glitch_busy_up", busy0, 1);
    hold(20);
    set_line(0, 1'b1); hold(80);
    chk("glitch_busy_down", busy0, 0);
    chk("glitch_no_byte", if0.rx_valid, 0);
    $display("txn glitch: 40 clk low pulse");

    // Framing error followed by break, then a clean byte.
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    model_frame(8'h3C, 1'b0);
    wait_valid(0, 200, "brk");
    chk_model("brk_byte");
    chk("brk_ferr_const", if0.frame_err, 1);
    do_hs(0);
    hold(2000);
    chk("brk_no_spurious", if0.rx_valid, 0);
    chk("brk_idle", busy0, 0);
    set_line(0, 1'b1); hold(200);
    send_frame(0, 8'h81, 1'b1, 1'b0, 1'b0);
    model_frame(8'h81, 1'b1);
    wait_valid(0, 200, "post_brk");
    chk_model("post_brk");
    do_hs(0);
    $display("txn break: 0x3C ferr then 0x81");

    // Overrun: two back-to-back frames, consumer stalled.
    send_frame(0, 8'h11, 1'b1, 1'b0, 1'b0);
    model_frame(8'h11, 1'b1);
    send_frame(0, 8'h22, 1'b1, 1'b0, 1'b0);
    model_frame(8'h22, 1'b1);
    hold(10);
    chk_model("ovr_pending");
    chk("ovr_data_const", if0.rx_data, 8'h11);
    chk("ovr_flag_const", if0.overrun, 1);
    do_hs(0);
    chk_model("ovr_after_hs");
    $display("txn overrun: 0x11 kept, 0x22 dropped");

    // Table of frames on both channels.
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].ch, tbl[i].d, tbl[i].stop, tbl[i].ch == 1, tbl[i].pbit);
      if (tbl[i].ch == 0) model_frame(tbl[i].d, tbl[i].stop);
      wait_valid(tbl[i].ch, 200, $sformatf("tbl%0d", i));
      if (tbl[i].ch == 0) begin
        chk($sformatf("tbl%0d_data", i), if0.rx_data, tbl[i].ed);
        chk($sformatf("tbl%0d_ferr", i), if0.frame_err, tbl[i].ef);
        chk($sformatf("tbl%0d_perr", i), if0.parity_err, tbl[i].ep);
      end else begin
        chk($sformatf("tbl%0d_data", i), if1.rx_data, tbl[i].ed);
        chk($sformatf("tbl%0d_ferr", i), if1.frame_err, tbl[i].ef);
        chk($sformatf("tbl%0d_perr", i), if1.parity_err, tbl[i].ep);
        chk($sformatf("tbl%0d_ovr", i), if1.overrun, 0);
      end
      do_hs(tbl[i].ch);
      chk($sformatf("tbl%0d_cleared", i), vld(tbl[i].ch), 0);
      set_line(tbl[i].ch, 1'b1); hold(40);
      $display("txn table %0d: ch=%0d data=%h stop=%0b", i, tbl[i].ch, tbl[i].d, tbl[i].stop);
    end

    // Reset in the middle of a frame, with a byte already pending.
    send_frame(0, 8'h33, 1'b1, 1'b0, 1'b0);
    model_frame(8'h33, 1'b1);
    hold(5);
    chk("pre_rst_pending", if0.rx_valid, 1);
    fork
      send_frame(0, 8'hFF, 1'b1, 1'b0, 1'b0);
      begin
        hold(BIT_CLKS * 5 + 70);
        rst = 1'b1;
        hold(3);
        chk("midrst_busy", busy0, 0);
        rst = 1'b0;
      end
    join
    model_reset();
    hold(40);
    chk_model("after_rst");
    chk("after_rst_busy", busy0, 0);
    send_frame(0, 8'h5A, 1'b1, 1'b0, 1'b0);
    model_frame(8'h5A, 1'b1);
    wait_valid(0, 200, "post_rst");
    chk_model("post_rst");
    do_hs(0);
    $display("txn midframe reset: then 0x5A");

    // Random frames with random consumer behaviour.
    for (int i = 0; i < 10; i++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(0, rd, rs, 1'b0, 1'b0);
      model_frame(rd, rs);
      set_line(0, 1'b1);
      hold(2 + $urandom_range(0, 40));
      chk_model($sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) do_hs(0);
      chk_model($sformatf("rnd%0d_post", i));
      $display("txn random %0d: data=%h stop=%0b", i, rd, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
